// File: rtl/cnn_layer_sched.sv
// Layer sequencer: drives the DMA engine and conv unit through one CNN layer descriptor.
// Optional DMA/conv handshake watchdog is enabled with `define CNN_LAYER_SCHED_TIMEOUT_EN.
module cnn_layer_sched #(
  parameter int ADDR_W  = 13,
  parameter int SIZE_W  = 5,
  parameter int KSIZE   = 5,
  parameter int NF_W    = 3,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [ADDR_W-1:0] cfg_img_base,
  input  logic [ADDR_W-1:0] cfg_filt_base,
  input  logic [ADDR_W-1:0] cfg_out_base,
  input  logic [SIZE_W-1:0] cfg_img_size,
  input  logic [NF_W-1:0]   cfg_num_filt,
  input  logic              cfg_pool,
  output logic              dma_start,
  input  logic              dma_finish,
  output logic [ADDR_W-1:0] dma_address,
  output logic              dma_write,
  output logic              dma_data_read,
  output logic              dma_pooling,
  output logic [SIZE_W-1:0] dma_image_size,
  output logic              cu_start,
  output logic [SIZE_W-1:0] cu_row,
  output logic [SIZE_W-1:0] cu_col,
  input  logic              cu_done,
  output logic              busy,
  output logic              layer_done,
  output logic              err,
  output logic [2:0]        dbg_state
);

  localparam int PW = NF_W + 2 * SIZE_W;

  // Handshakes: a DMA request is held on dma_start (with address/mode/size stable)
  // until dma_finish is sampled high, then drops for at least one cycle; a conv
  // window is one cu_start pulse answered by cu_done, with no new window until then.
  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LD_IMG  = 3'd1,
    S_LD_FILT = 3'd2,
    S_CONV    = 3'd3,
    S_POOL    = 3'd4,
    S_STORE   = 3'd5,
    S_DONE    = 3'd6,
    S_REJECT  = 3'd7
  } state_t;

  state_t             r_state, w_state_next;
  logic [ADDR_W-1:0]  r_img_base, r_filt_base, r_out_base;
  logic [SIZE_W-1:0]  r_n, r_o, r_p, r_row, r_col;
  logic [NF_W-1:0]    r_nf, r_f;
  logic               r_pool, r_req, r_cu_wait, r_err;

  logic               w_dma_state, w_dma_fin, w_cu_fin, w_win_last, w_last_filt;
  logic               w_accept, w_cfg_bad, w_timeout;
  logic [SIZE_W-1:0]  w_o_new, w_o_m1, w_s;
  logic [PW-1:0]      w_filt_off, w_store_off;
  logic [ADDR_W-1:0]  w_filt_addr, w_store_addr;

  assign w_dma_state  = (r_state == S_LD_IMG) || (r_state == S_LD_FILT) ||
                        (r_state == S_POOL)   || (r_state == S_STORE);
  assign w_dma_fin    = w_dma_state && r_req && dma_finish;
  assign w_cu_fin     = (r_state == S_CONV) && r_cu_wait && cu_done;
  assign w_o_m1       = r_o - SIZE_W'(1);
  assign w_win_last   = (r_row == w_o_m1) && (r_col == w_o_m1);
  assign w_last_filt  = ({1'b0, r_f} + (NF_W+1)'(1)) >= {1'b0, r_nf};
  assign w_accept     = cfg_valid && (r_state == S_IDLE);
  assign w_cfg_bad    = (cfg_img_size < SIZE_W'(KSIZE)) || (cfg_num_filt == '0);
  assign w_o_new      = cfg_img_size - SIZE_W'(KSIZE - 1);
  assign w_s          = r_pool ? r_p : r_o;
  // Offsets are formed at full product width, then wrap into the address space.
  assign w_filt_off   = PW'(r_f) * PW'(KSIZE * KSIZE);
  assign w_store_off  = PW'(r_f) * PW'(w_s) * PW'(w_s);
  assign w_filt_addr  = r_filt_base + ADDR_W'(w_filt_off);
  assign w_store_addr = r_out_base + ADDR_W'(w_store_off);

`ifdef CNN_LAYER_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] r_wdog;
  logic          w_waiting;

  assign w_waiting = (w_dma_state && r_req && !dma_finish) ||
                     ((r_state == S_CONV) && r_cu_wait && !cu_done);
  assign w_timeout = w_waiting && (r_wdog == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_wdog <= '0;
    else if (!w_waiting) r_wdog <= '0;
    else                 r_wdog <= r_wdog + TW'(1);
  end
`else
  logic w_unused_timeout;
  assign w_timeout        = 1'b0;
  assign w_unused_timeout = ^TIMEOUT;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:    if (w_accept) w_state_next = w_cfg_bad ? S_REJECT : S_LD_IMG;
      S_LD_IMG:  if (w_dma_fin) w_state_next = S_LD_FILT;
      S_LD_FILT: if (w_dma_fin) w_state_next = S_CONV;
      S_CONV: begin
        if (w_cu_fin && w_win_last) begin
          // A 1x1 conv result has nothing left after pooling: skip pool and store.
          if (r_pool && (r_p == '0)) w_state_next = w_last_filt ? S_DONE : S_LD_FILT;
          else                       w_state_next = r_pool ? S_POOL : S_STORE;
        end
      end
      S_POOL:    if (w_dma_fin) w_state_next = S_STORE;
      S_STORE:   if (w_dma_fin) w_state_next = w_last_filt ? S_DONE : S_LD_FILT;
      default:   w_state_next = S_IDLE;
    endcase
    if (w_timeout) w_state_next = S_DONE;
  end

  always_comb begin
    dma_address    = '0;
    dma_image_size = '0;
    dma_write      = 1'b0;
    dma_data_read  = 1'b0;
    dma_pooling    = 1'b0;
    case (r_state)
      S_LD_IMG: begin
        dma_address    = r_img_base;
        dma_image_size = r_n;
      end
      S_LD_FILT: begin
        dma_address    = w_filt_addr;
        dma_image_size = SIZE_W'(KSIZE);
        dma_data_read  = 1'b1;
      end
      S_POOL: begin
        dma_address    = w_store_addr;
        dma_image_size = r_o;
        dma_data_read  = 1'b1;
        dma_pooling    = 1'b1;
      end
      S_STORE: begin
        dma_address    = w_store_addr;
        dma_image_size = w_s;
        dma_write      = 1'b1;
      end
      default: ;
    endcase
  end

  assign cfg_ready  = (r_state == S_IDLE);
  assign busy       = !((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_REJECT));
  assign layer_done = (r_state == S_DONE) || (r_state == S_REJECT);
  assign dma_start  = r_req;
  assign cu_start   = (r_state == S_CONV) && !r_cu_wait;
  assign cu_row     = r_row;
  assign cu_col     = r_col;
  assign err        = r_err;
  assign dbg_state  = r_state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_img_base  <= '0;
      r_filt_base <= '0;
      r_out_base  <= '0;
      r_n         <= '0;
      r_o         <= '0;
      r_p         <= '0;
      r_nf        <= '0;
      r_pool      <= 1'b0;
      r_f         <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_req       <= 1'b0;
      r_cu_wait   <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_img_base  <= cfg_img_base;
        r_filt_base <= cfg_filt_base;
        r_out_base  <= cfg_out_base;
        r_n         <= cfg_img_size;
        r_o         <= w_o_new;
        r_p         <= w_o_new >> 1;
        r_nf        <= cfg_num_filt;
        r_pool      <= cfg_pool;
        r_f         <= '0;
        r_err       <= w_cfg_bad;
      end
      if (w_timeout) r_err <= 1'b1;
      // The request rises one cycle after entering a DMA state, which also
      // guarantees the idle cycle between back-to-back requests.
      if (w_timeout || w_dma_fin)     r_req <= 1'b0;
      else if (w_dma_state && !r_req) r_req <= 1'b1;
      if (r_state != S_CONV) begin
        r_row     <= '0;
        r_col     <= '0;
        r_cu_wait <= 1'b0;
      end else if (!r_cu_wait) begin
        r_cu_wait <= 1'b1;
      end else if (cu_done) begin
        r_cu_wait <= 1'b0;
        if (r_col == w_o_m1) begin
          r_col <= '0;
          r_row <= r_row + SIZE_W'(1);
        end else begin
          r_col <= r_col + SIZE_W'(1);
        end
      end
      if (((r_state == S_STORE) || (r_state == S_CONV)) && (w_state_next == S_LD_FILT))
        r_f <= r_f + NF_W'(1);
    end
  end

endmodule

// File: tb/tb_cnn_layer_sched.sv
// Bench for cnn_layer_sched: randomized DMA/conv responders, an event monitor and a
// layer-level reference model that builds the expected DMA/conv event list per descriptor.
module tb_cnn_layer_sched;
  localparam int ADDR_W  = 13;
  localparam int SIZE_W  = 5;
  localparam int KSIZE   = 5;
  localparam int NF_W    = 3;
  localparam int TIMEOUT = 1023;
  localparam int AMOD    = 1 << ADDR_W;
  localparam logic [31:0] DONE_EV = 32'h8000_0000;

  logic              clk, rst_n, cfg_valid, cfg_ready, cfg_pool;
  logic [ADDR_W-1:0] cfg_img_base, cfg_filt_base, cfg_out_base, dma_address;
  logic [SIZE_W-1:0] cfg_img_size, dma_image_size, cu_row, cu_col;
  logic [NF_W-1:0]   cfg_num_filt;
  logic              dma_start, dma_finish, dma_write, dma_data_read, dma_pooling;
  logic              cu_start, cu_done, busy, layer_done, err;
  logic [2:0]        dbg_state;

  cnn_layer_sched #(.ADDR_W(ADDR_W), .SIZE_W(SIZE_W), .KSIZE(KSIZE), .NF_W(NF_W),
                    .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_img_base(cfg_img_base), .cfg_filt_base(cfg_filt_base), .cfg_out_base(cfg_out_base),
    .cfg_img_size(cfg_img_size), .cfg_num_filt(cfg_num_filt), .cfg_pool(cfg_pool),
    .dma_start(dma_start), .dma_finish(dma_finish), .dma_address(dma_address),
    .dma_write(dma_write), .dma_data_read(dma_data_read), .dma_pooling(dma_pooling),
    .dma_image_size(dma_image_size), .cu_start(cu_start), .cu_row(cu_row), .cu_col(cu_col),
    .cu_done(cu_done), .busy(busy), .layer_done(layer_done), .err(err), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0, errors = 0, viol = 0, done_cnt = 0, cu_cnt = 0;
  int dmin = 0, dmax = 3, cu_dmax = 5;
  bit dma_never = 0, spurious_en = 1;
  logic [31:0] exp_q[$], obs_q[$];

  function automatic logic [31:0] ev_dma(input logic [12:0] a, input logic [4:0] s,
                                         input logic w, input logic dr, input logic pl);
    return {2'b00, 9'd0, w, dr, pl, s, a};
  endfunction

  function automatic logic [31:0] ev_cu(input logic [4:0] r, input logic [4:0] c);
    return {2'b01, 20'd0, r, c};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic cyc(input int k);
    repeat (k) begin @(posedge clk); #1; end
  endtask

  // DMA responder: finishes each request after a random delay, pulses spurious finishes when idle.
  initial begin : dma_resp
    int dcnt, dtarget;
    dma_finish = 1'b0; dcnt = 0; dtarget = 0;
    forever begin
      @(posedge clk); #1;
      dma_finish = 1'b0;
      if (!rst_n) dcnt = 0;
      else if (dma_start) begin
        if (!dma_never) begin
          if (dcnt == 0) dtarget = $urandom_range(dmax, dmin);
          if (dcnt >= dtarget) begin dma_finish = 1'b1; dcnt = 0; end
          else dcnt++;
        end
      end else begin
        dcnt = 0;
        if (spurious_en && $urandom_range(3, 0) == 0) dma_finish = 1'b1;
      end
    end
  end

  // Conv-unit responder: answers each window 1..cu_dmax+1 cycles after cu_start.
  initial begin : cu_resp
    bit pend; int ccnt;
    cu_done = 1'b0; pend = 0; ccnt = 0;
    forever begin
      @(posedge clk); #1;
      cu_done = 1'b0;
      if (!rst_n) pend = 0;
      else begin
        if (pend) begin
          if (ccnt == 0) begin cu_done = 1'b1; pend = 0; end
          else ccnt--;
        end else if (!cu_start && spurious_en && $urandom_range(3, 0) == 0) cu_done = 1'b1;
        if (cu_start) begin pend = 1; ccnt = $urandom_range(cu_dmax, 0); end
      end
    end
  end

  // Monitor: records DMA requests, conv windows and layer_done; counts protocol violations.
  initial begin : monitor
    logic p_start, p_fin, cu_outs;
    logic [31:0] cur_ev, ev;
    p_start = 0; p_fin = 0; cu_outs = 0; cur_ev = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin p_start = 0; p_fin = 0; cu_outs = 0; end
      else begin
        ev = ev_dma(dma_pooling ? 13'd0 : dma_address, dma_image_size, dma_write,
                    dma_data_read, dma_pooling);
        if (dma_start && !p_start) begin obs_q.push_back(ev); cur_ev = ev; end
        if (dma_start && p_start && (p_fin || ev !== cur_ev)) viol++;
        if (!dma_start && p_start && !p_fin) viol++;
        if (dma_start && cu_start) viol++;
        if (busy && (cfg_ready || layer_done)) viol++;
        if (cu_start) begin
          if (cu_outs) viol++;
          obs_q.push_back(ev_cu(cu_row, cu_col));
          cu_cnt++;
        end
        if (cu_done) cu_outs = 0;
        if (cu_start) cu_outs = 1;
        if (layer_done) begin obs_q.push_back(DONE_EV); done_cnt++; end
        p_start = dma_start; p_fin = dma_finish;
      end
    end
  end

  // Reference model: expected event list of one descriptor.
  task automatic model_layer(input int ib, input int fb, input int ob, input int n,
                             input int nf, input bit pl, output bit e_err);
    int o, p, s;
    if (n < KSIZE || nf == 0) begin exp_q.push_back(DONE_EV); e_err = 1; return; end
    e_err = 0;
    o = n - KSIZE + 1;
    p = o / 2;
    s = pl ? p : o;
    exp_q.push_back(ev_dma(13'(ib), 5'(n), 0, 0, 0));
    for (int f = 0; f < nf; f++) begin
      exp_q.push_back(ev_dma(13'((fb + f * KSIZE * KSIZE) % AMOD), 5'(KSIZE), 0, 1, 0));
      for (int r = 0; r < o; r++)
        for (int c = 0; c < o; c++) exp_q.push_back(ev_cu(5'(r), 5'(c)));
      if (!(pl && p == 0)) begin
        if (pl) exp_q.push_back(ev_dma(13'd0, 5'(o), 0, 1, 1));
        exp_q.push_back(ev_dma(13'((ob + f * s * s) % AMOD), 5'(s), 1, 0, 0));
      end
    end
    exp_q.push_back(DONE_EV);
  endtask

  // Driver: holds the descriptor until accepted.
  task automatic send_desc(input int ib, input int fb, input int ob, input int n,
                           input int nf, input bit pl);
    bit ok, rdy, bad;
    cfg_img_base = 13'(ib); cfg_filt_base = 13'(fb); cfg_out_base = 13'(ob);
    cfg_img_size = 5'(n); cfg_num_filt = 3'(nf); cfg_pool = pl;
    cfg_valid = 1'b1; ok = 0;
    bad = (n < KSIZE) || (nf == 0);
    for (int i = 0; i < 30000 && !ok; i++) begin
      rdy = cfg_ready;
      cyc(1);
      if (rdy) ok = 1;
    end
    cfg_valid = 1'b0;
    chk("accept", 32'(ok), 32'd1);
    chk("err_after_accept", 32'(err), 32'(bad));
    chk("busy_after_accept", 32'(busy), 32'(!bad));
  endtask

  task automatic wait_done(input string tag, input bit e_err);
    bit found = 0;
    for (int i = 0; i < 30000 && !found; i++) begin
      if (layer_done) found = 1;
      else cyc(1);
    end
    chk({tag, "_done_seen"}, 32'(found), 32'd1);
    if (found) begin
      chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
      chk({tag, "_ready_at_done"}, 32'(cfg_ready), 32'd0);
      chk({tag, "_err_at_done"}, 32'(err), 32'(e_err));
      cyc(1);
      chk({tag, "_done_one_cycle"}, 32'(layer_done), 32'd0);
      chk({tag, "_ready_after_done"}, 32'(cfg_ready), 32'd1);
    end
    cyc(2);
  endtask

  task automatic compare_q(input string tag);
    int n, bad;
    bad = 0;
    chk({tag, "_len"}, 32'(obs_q.size()), 32'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      if (bad < 3) begin
        if (obs_q[i] !== exp_q[i]) bad++;
        chk($sformatf("%s_ev%0d", tag, i), obs_q[i], exp_q[i]);
      end
    end
    chk({tag, "_protocol"}, 32'(viol), 32'd0);
    viol = 0;
    obs_q.delete();
    exp_q.delete();
  endtask

  task automatic run_layer(input string tag, input int ib, input int fb, input int ob,
                           input int n, input int nf, input bit pl);
    bit e_err;
    model_layer(ib, fb, ob, n, nf, pl, e_err);
    send_desc(ib, fb, ob, n, nf, pl);
    wait_done(tag, e_err);
    chk({tag, "_err_final"}, 32'(err), 32'(e_err));
    compare_q(tag);
  endtask

  initial begin : main
    bit e_a, e_b, reached;
    int d0, c0;
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_pool = 1'b0;
    cfg_img_base = '0; cfg_filt_base = '0; cfg_out_base = '0;
    cfg_img_size = '0; cfg_num_filt = '0;
    #1;
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dma_start", 32'(dma_start), 32'd0);
    chk("rst_cu_start", 32'(cu_start), 32'd0);
    chk("rst_layer_done", 32'(layer_done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_dma_address", 32'(dma_address), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    cyc(3);
    rst_n = 1'b1;
    cyc(2);

    run_layer("basic", 'h100, 'h040, 'h400, 8, 1, 0);
    run_layer("pool2", 'h000, 'h040, 'h800, 12, 2, 1);
    run_layer("reject_n4", 'h010, 'h020, 'h030, 4, 1, 0);
    run_layer("min_n5", 'h010, 'h020, 'h030, 5, 1, 0);
    run_layer("reject_f0", 'h010, 'h020, 'h030, 9, 0, 1);
    run_layer("skip_p0", 'h011, 'h022, 'h033, 5, 2, 1);
    run_layer("wrap", 'h000, 'h1FF0, 'h1FF0, 20, 3, 0);

    dmin = 37; dmax = 37;
    run_layer("slow_dma", 'h123, 'h456, 'h789, 6, 2, 1);
    dmin = 0; dmax = 4;

    // A second descriptor presented while busy must wait, not be lost.
    model_layer('h050, 'h060, 'h070, 6, 1, 0, e_a);
    model_layer('h150, 'h160, 'h170, 7, 2, 1, e_b);
    d0 = done_cnt;
    send_desc('h050, 'h060, 'h070, 6, 1, 0);
    send_desc('h150, 'h160, 'h170, 7, 2, 1);
    reached = 0;
    for (int i = 0; i < 5000 && !reached; i++) begin
      if (done_cnt >= d0 + 2) reached = 1;
      else cyc(1);
    end
    chk("held_done_seen", 32'(reached), 32'd1);
    cyc(3);
    compare_q("held");

    for (int k = 0; k < 6; k++) begin
      int n, nf;
      n  = $urandom_range(12, 3);
      nf = (k == 2) ? 0 : $urandom_range(3, 1);
      run_layer($sformatf("rand%0d", k), $urandom_range(AMOD - 1, 0),
                $urandom_range(AMOD - 1, 0), $urandom_range(AMOD - 1, 0), n, nf,
                1'($urandom_range(1, 0)));
    end

    // Reset in the middle of convolution.
    c0 = cu_cnt;
    send_desc('h200, 'h300, 'h400, 10, 1, 0);
    reached = 0;
    for (int i = 0; i < 500 && !reached; i++) begin
      if (cu_cnt >= c0 + 3) reached = 1;
      else cyc(1);
    end
    chk("midconv_reached", 32'(reached), 32'd1);
    chk("midconv_protocol", 32'(viol), 32'd0);
    d0 = done_cnt;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("arst_dma_start", 32'(dma_start), 32'd0);
    chk("arst_cu_start", 32'(cu_start), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("arst_layer_done", 32'(layer_done), 32'd0);
    chk("arst_cu_row", 32'(cu_row), 32'd0);
    cyc(3);
    rst_n = 1'b1;
    cyc(1);
    chk("post_rst_ready", 32'(cfg_ready), 32'd1);
    cyc(20);
    chk("post_rst_no_done", 32'(done_cnt), 32'(d0));
    chk("post_rst_busy", 32'(busy), 32'd0);
    obs_q.delete();
    viol = 0;
    run_layer("recover", 'h001, 'h002, 'h003, 6, 1, 1);

`ifdef CNN_LAYER_SCHED_TIMEOUT_EN
    dma_never = 1;
    c0 = 0;
    send_desc('h100, 'h040, 'h400, 8, 1, 0);
    reached = 0;
    for (int i = 0; i < TIMEOUT + 200 && !reached; i++) begin
      if (layer_done) reached = 1;
      else begin cyc(1); c0++; end
    end
    chk("timeout_done", 32'(reached), 32'd1);
    chk("timeout_err", 32'(err), 32'd1);
    chk("timeout_dma_dropped", 32'(dma_start), 32'd0);
    chk("timeout_latency_ok", 32'(c0 >= TIMEOUT && c0 <= TIMEOUT + 4), 32'd1);
    dma_never = 0;
    cyc(3);
    obs_q.delete();
    viol = 0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cnn_layer_sched.md
Name: cnn_layer_sched

Overview:
- Layer-level sequencer for the CNN DMA engine and the convolution unit.
- Accepts one layer descriptor: image/filter/output base addresses, image size, filter count and pooling enable.
- Per filter it issues the DMA transfer sequence: load image (once), load filter, step conv windows, optional 2x2 pool, store result.
- Sits between the top-level control and the DMA / conv-unit pair. It is the only master driving DMA start, address and mode.

Parameters:
ADDR_W, 13, RAM address width
SIZE_W, 5, image-size width (max 31)
KSIZE, 5, filter side length
NF_W, 3, filter-count width (1..7 filters per layer)
TIMEOUT, 1023, watchdog cycles per DMA/conv handshake (optional feature only)

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cfg_valid  in  1  descriptor valid
cfg_ready  out  1  scheduler idle, descriptor accepted when valid&ready
cfg_img_base  in  ADDR_W  image base address
cfg_filt_base  in  ADDR_W  filter bank base address (filters packed, KSIZE*KSIZE words each)
cfg_out_base  in  ADDR_W  output base address
cfg_img_size  in  SIZE_W  image side N
cfg_num_filt  in  NF_W  filter count F
cfg_pool  in  1  apply 2x2 pooling after each convolution
dma_start  out  1  DMA request, level
dma_finish  in  1  DMA transfer complete
dma_address  out  ADDR_W  DMA RAM start address
dma_write  out  1  1 = DMA writes RAM, 0 = DMA reads RAM
dma_data_read  out  1  1 = DMA drives data bus to datapath
dma_pooling  out  1  DMA pooling window mode
dma_image_size  out  SIZE_W  transfer side length
cu_start  out  1  one-cycle pulse: conv unit computes window
cu_row  out  SIZE_W  window top row
cu_col  out  SIZE_W  window left column
cu_done  in  1  conv unit window result written
busy  out  1  descriptor in progress
layer_done  out  1  one-cycle pulse at end of layer
err  out  1  sticky error, cleared on next accepted descriptor

Behaviour:
- Reset (async, rst_n=0): state IDLE; cfg_ready=1; all other outputs 0; counters and latched descriptor cleared. Reset mid-transfer abandons the layer immediately, with no completion pulse.
- Descriptor acceptance: on valid&ready the descriptor is latched. O=N-4 and P=O>>1 are computed.
  - N<KSIZE or F=0 is rejected: err=1, no DMA activity, layer_done pulses the next cycle, return to IDLE.
- States: IDLE -> LD_IMG -> LD_FILT -> CONV -> [POOL] -> STORE -> (f+1<F ? LD_FILT : DONE) -> IDLE.
- DMA handshake in every DMA state:
  - dma_start rises on state entry together with stable address/mode/size.
  - It holds until dma_finish=1 is sampled, deasserts on the following cycle, and the state advances that same cycle.
  - Minimum one cycle of dma_start=0 between consecutive requests.
  - dma_finish seen while dma_start=0 is ignored.
- LD_IMG: address=img_base, size=N, write=0, data_read=0, pooling=0.
- LD_FILT: address=filt_base+f*25 (mod 2^ADDR_W), size=KSIZE, write=0, data_read=1.
- CONV:
  - For r in 0..O-1, c in 0..O-1 (row-major), issue cu_start with cu_row=r, cu_col=c.
  - Wait for cu_done before issuing the next window. The next cu_start comes no earlier than 1 cycle after cu_done.
  - cu_done outside a wait is ignored.
  - Total O*O pulses.
- POOL (cfg_pool=1 only): size=O, data_read=1, pooling=1, write=0.
- STORE: write=1, data_read=0.
  - Address: out_base+f*S*S, where S=P if pooling else O.
  - size=S.
  - Address arithmetic wraps mod 2^ADDR_W; the product is computed at full width before truncation.
- P=0 (O=1 with pooling) skips POOL and STORE for that filter.
- DONE: layer_done pulses one cycle, busy drops the same cycle, cfg_ready=1 the next cycle.
- busy = !cfg_ready except during the reject cycle.
- cfg_valid while busy is ignored, with no back-pressure loss: the descriptor is held by the requester.

Optional Feature:
- Macro: CNN_LAYER_SCHED_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles while waiting on dma_finish or cu_done.
  - Reaching TIMEOUT sets err=1, drops dma_start, pulses layer_done, and returns to IDLE.
  - The counter clears on every handshake completion.
- Undefined: no counter; waits are unbounded; err is set only by descriptor rejection.

Test Plan:
- N=8, F=1, pool=0, img_base=0x100, filt_base=0x040, out_base=0x400 -> DMA sequence LD_IMG(0x100,8), LD_FILT(0x040,5), 16 cu_start pulses (r,c 0..3 row-major), STORE(0x400,size 4,write=1), one layer_done.
- N=12, F=2, pool=1, filt_base=0x040, out_base=0x800 -> LD_FILT at 0x040 then 0x059; 64 cu_start per filter; POOL size 8; STORE at 0x800 then 0x810, size 4.
- N=4 -> err=1, zero dma_start cycles, layer_done one cycle after acceptance; next valid N=5 descriptor clears err and issues 1 cu_start.
- out_base=0x1FF0, N=20, F=3, pool=0 -> third STORE address (0x1FF0+512) mod 8192 = 0x01F0.
- dma_finish delayed 37 cycles, cu_done delayed 0..5 random -> dma_start held until finish; no overlapping requests; cu_start count exact.
- rst_n asserted mid-CONV -> all outputs 0 asynchronously, cfg_ready=1 after release, no layer_done.
- With the timeout macro defined, dma_finish never arriving -> err=1 and layer_done after TIMEOUT cycles.
